// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: slot prescaler, per-frame input
// snapshot, dead-time blanking, leading-zero suppression and registered cathodes.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [1:0]  refresh_count,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;

  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    rc_nx;
  logic [15:0]   sh_digits, sh_digits_nx;
  logic [3:0]    sh_dp, sh_dp_nx;
  logic          sh_lz, sh_lz_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic          tick_nx;
  logic [3:0]    nib;
  logic          suppress;
  logic          frame_start;

  // Active-low {g..a} patterns for hex digits
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt           <= '0;
      refresh_count <= '0;
      sh_digits     <= '0;
      sh_dp         <= '0;
      sh_lz         <= 1'b0;
      seg           <= SEG_OFF;
      dp            <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      cnt           <= cnt_nx;
      refresh_count <= rc_nx;
      sh_digits     <= sh_digits_nx;
      sh_dp         <= sh_dp_nx;
      sh_lz         <= sh_lz_nx;
      seg           <= seg_nx;
      dp            <= dp_nx;
      frame_tick    <= tick_nx;
    end
  end

  // Cathodes are derived from the next-state slot/shadow so they line up with refresh_count
  always_comb begin
    cnt_nx       = cnt;
    rc_nx        = refresh_count;
    sh_digits_nx = sh_digits;
    sh_dp_nx     = sh_dp;
    sh_lz_nx     = sh_lz;
    seg_nx       = SEG_OFF;
    dp_nx        = 1'b1;
    tick_nx      = 1'b0;
    nib          = 4'h0;
    suppress     = 1'b0;
    frame_start  = (cnt == '0) && (refresh_count == 2'd0);

    if (enable) begin
      if (frame_start) begin
        sh_digits_nx = digits;
        sh_dp_nx     = dp_in;
        sh_lz_nx     = blank_lz;
        tick_nx      = 1'b1;
      end
      if (cnt == CNT_LAST) begin
        cnt_nx = '0;
        rc_nx  = refresh_count + 2'd1;
      end else begin
        cnt_nx = cnt + CW'(1);
      end

      nib = sh_digits_nx[{rc_nx, 2'b00} +: 4];
      case (rc_nx)
        2'd3:    suppress = sh_lz_nx && (sh_digits_nx[15:12] == 4'h0);
        2'd2:    suppress = sh_lz_nx && (sh_digits_nx[15:8] == 8'h00);
        2'd1:    suppress = sh_lz_nx && (sh_digits_nx[15:4] == 12'h000);
        default: suppress = 1'b0;
      endcase

      if ((cnt_nx >= CNT_BLANK) && !suppress) begin
        seg_nx = decode(nib);
        dp_nx  = ~sh_dp_nx[rc_nx];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a driver pushes model predictions per
// cycle, a monitor pops and compares them against the registered outputs.
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [1:0]  refresh_count;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .digits(digits),
    .dp_in(dp_in), .blank_lz(blank_lz), .refresh_count(refresh_count),
    .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rc;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;
  bit   done = 0;

  // Reference glyph table indexed by nibble value
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Behavioural scan model: position within frame plus the frame snapshot
  int m_cnt = 0, m_rc = 0;
  int m_dig = 0, m_dpi = 0, m_lz = 0;

  function automatic bit lz_hidden(int dig, int lz, int pos);
    return (lz != 0) && (pos > 0) && ((dig >> (4 * pos)) == 0);
  endfunction

  task automatic model_step(output exp_t e);
    e.cyc = cycle_no;
    if (!reset_n) begin
      m_cnt = 0; m_rc = 0; m_dig = 0; m_dpi = 0; m_lz = 0;
      e.rc = 2'd0; e.seg = 7'h7f; e.dp = 1'b1; e.ft = 1'b0;
    end else if (!enable) begin
      e.rc = 2'(m_rc); e.seg = 7'h7f; e.dp = 1'b1; e.ft = 1'b0;
    end else begin
      e.ft = (m_cnt == 0 && m_rc == 0);
      if (e.ft) begin
        m_dig = int'(digits); m_dpi = int'(dp_in); m_lz = int'(blank_lz);
      end
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_rc = (m_rc + 1) % 4;
      end
      e.rc = 2'(m_rc);
      if (m_cnt >= BLANK && !lz_hidden(m_dig, m_lz, m_rc)) begin
        e.seg = glyph[(m_dig >> (4 * m_rc)) & 15];
        e.dp  = ((m_dpi >> m_rc) & 1) == 0;
      end else begin
        e.seg = 7'h7f;
        e.dp  = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic en, input logic [15:0] d,
                     input logic [3:0] p, input logic lz);
    exp_t e;
    @(negedge clk);
    reset_n = rst; enable = en; digits = d; dp_in = p; blank_lz = lz;
    cycle_no++;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, digits, dp_in, blank_lz);
  endtask

  task automatic check(input string name, input int cy, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cy, got, want);
    end
  endtask

  // Monitor: compare one prediction per clock, sampled just after the edge
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("refresh_count", e.cyc, int'(refresh_count), int'(e.rc));
        check("seg", e.cyc, int'(seg), int'(e.seg));
        check("dp", e.cyc, int'(dp), int'(e.dp));
        check("frame_tick", e.cyc, int'(frame_tick), int'(e.ft));
      end
    end
  end

  initial begin
    int guard;
    // Reset with enable high, then free-running decode of 1208
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h1208, 4'b0100, 1'b0);
    run(70);

    // Leading-zero suppression
    cyc(1'b1, 1'b1, 16'h0050, 4'b0000, 1'b1);
    run(70);
    cyc(1'b1, 1'b1, 16'h0000, 4'b1111, 1'b1);
    run(70);

    // Snapshot integrity: change inputs mid-frame in slot1
    cyc(1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0);
    run(40);
    guard = 0;
    while (m_rc != 1 && guard < 64) begin run(1); guard++; end
    check("reach_slot1", cycle_no, m_rc, 1);
    cyc(1'b1, 1'b1, 16'h5678, 4'b0000, 1'b0);
    run(70);

    // Enable freeze at slot2, cnt 5
    guard = 0;
    while (!(m_rc == 2 && m_cnt == 5) && guard < 64) begin run(1); guard++; end
    check("reach_freeze_point", cycle_no, m_rc * 16 + m_cnt, 2 * 16 + 5);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, digits, dp_in, blank_lz);
    run(40);

    // Reset for one cycle in slot3
    guard = 0;
    while (m_rc != 3 && guard < 64) begin run(1); guard++; end
    check("reach_slot3", cycle_no, m_rc, 3);
    cyc(1'b0, 1'b1, digits, dp_in, blank_lz);
    run(70);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] d;
      logic [3:0]  p;
      logic        lz;
      d  = digits; p = dp_in; lz = blank_lz;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: d = 16'($urandom_range(0, 255));
          1: d = 16'($urandom_range(0, 15)) << 8;
          default: d = 16'($urandom);
        endcase
        p  = 4'($urandom);
        lz = 1'($urandom);
      end
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0), d, p, lz);
    end

    @(negedge clk);
    @(negedge clk);
    done = 1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display. It sits directly upstream of the anode decoder. It generates the 2-bit `refresh_count` that selects the active anode, and drives the active-low cathode lines (`seg`, `dp`) for that digit. It also provides a per-frame snapshot of the BCD inputs, anti-ghosting dead time, and leading-zero suppression.

## Interface
- `REFRESH_DIV`, 100000 — clock cycles per digit slot (1 kHz slot rate, 250 Hz frame at 100 MHz); must be ≥ 2.
- `BLANK_CYCLES`, 1000 — dead-time cycles at the start of each slot; 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.
- `clk` in 1 — system clock; single clock domain.
- `reset_n` in 1 — synchronous, active-low reset.
- `enable` in 1 — scan run; low freezes the scan and blanks the display.
- `digits` in 16 — four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in` in 4 — decimal point request per digit, active-high; bit i is digit i.
- `blank_lz` in 1 — leading-zero suppression enable.
- `refresh_count` out 2 — active digit index, fed to the anode decoder.
- `seg` out 7 — cathodes {g,f,e,d,c,b,a}, active-low.
- `dp` out 1 — decimal point cathode, active-low.
- `frame_tick` out 1 — one-cycle pulse at the start of each frame.

## Operation
- **Prescaler `cnt`:** counts 0..REFRESH_DIV-1 while `enable`=1.
  - At REFRESH_DIV-1, `cnt`→0 and `refresh_count` increments modulo 4 (3→0 wraps).
- **Shadow register:** {`digits`, `dp_in`, `blank_lz`} is captured into a shadow register on any enabled cycle where `cnt`=0 and `refresh_count`=0. That is the first slot of each frame, including the first enabled cycle after reset. All display decisions use the shadow only, so a frame never tears.
- **Decode:** the selected shadow nibble is decoded to `seg`, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Blanked slot:** `seg`=1111111 and `dp`=1. A slot is blanked when any of the following holds:
  - `cnt` < `BLANK_CYCLES` (dead time, every slot);
  - `enable`=0;
  - the digit is leading-zero suppressed.
- **Leading-zero suppression:** applies when shadow `blank_lz`=1.
  - Digit 3 is suppressed if nibble3=0.
  - Digit 2 is suppressed if nibble3 and nibble2 are both 0.
  - Digit 1 is suppressed if nibbles 3..1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit also suppresses its `dp`.
- **Decimal point:** `dp` = ~shadow dp bit of the selected digit, outside blanking.
- **Output alignment:** `seg`, `dp`, `refresh_count` and `frame_tick` are all registered. `seg`/`dp` are computed from the next-state `cnt`/`refresh_count`, so on every cycle they correspond to the currently visible `refresh_count`. There is no one-cycle ghost of the previous digit.
- **`enable`=0:**
  - `cnt`, `refresh_count` and the shadow hold.
  - `seg`=1111111, `dp`=1, `frame_tick`=0.
  - When `enable` returns to 1, the scan resumes from the held `cnt`/`refresh_count`.
- **Reset (`reset_n`=0 at a clock edge):** `cnt`=0, `refresh_count`=0, shadow=0, `seg`=1111111, `dp`=1, `frame_tick`=0. Reset mid-slot aborts that slot immediately.

## Timing
- Slot length is exactly `REFRESH_DIV` cycles; frame length is 4×`REFRESH_DIV`.
- `refresh_count` changes on the edge after `cnt`=REFRESH_DIV-1.
- Visible lit window per slot is `cnt` in [BLANK_CYCLES, REFRESH_DIV-1], i.e. REFRESH_DIV−BLANK_CYCLES cycles.
- `frame_tick`=1 exactly on the cycle(s) where `refresh_count`=0 and `cnt`=0 and `enable`=1. That is one cycle per frame, coincident with the shadow load.
- Input-to-display latency:
  - New `digits` take effect at the next frame start, at most 4×`REFRESH_DIV` cycles later.
  - They become visible after a further `BLANK_CYCLES`.
- All outputs are glitch-free registers. There is no combinational path from inputs to outputs.

## Test plan
Bench parameters: `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- **Reset and scan sequence:** hold `reset_n`=0 for 5 cycles with `enable`=1 → `refresh_count`=0, `seg`=1111111, `dp`=1, `frame_tick`=0. After release → `refresh_count` steps 0,1,2,3,0 every 8 cycles, and `frame_tick` pulses once every 32 cycles, on the first cycle after release.
- **Decode and dead time:** `digits`=16'h1208, `dp_in`=4'b0100, `blank_lz`=0 →
  - Each slot shows `seg`=1111111 for cycles 0–1, then the digit for cycles 2–7.
  - Slot0 shows 0000000; slot1 shows 1000000; slot2 shows 0100100 with `dp`=0; slot3 shows 1111001.
- **Leading-zero suppression:**
  - `digits`=16'h0050, `blank_lz`=1 → slots 3 and 2 fully blank; slot1 shows 0010010; slot0 shows 1000000.
  - `digits`=16'h0000 → only slot0 is lit, showing 1000000.
- **Snapshot integrity:** change `digits` from 16'h1234 to 16'h5678 during slot1 → slots 2–3 of that frame still show 2 and 1. The next frame shows 8,7,6,5.
- **Enable freeze:** drop `enable` at slot2, `cnt`=5, for 10 cycles → `refresh_count` stays 2, `seg`=1111111, no `frame_tick`. Re-assert → slot2 completes its remaining lit cycles `cnt`=5..7, then advances to 3.
- **Reset mid-operation:** assert `reset_n`=0 for 1 cycle in slot3 → the next cycle shows `refresh_count`=0 and `seg`=1111111. The scan restarts with a `frame_tick` and a new shadow load.
